// File: rtl/pattern_bist_driver_pkg.sv
// Shared types, default polynomials and LFSR/MISR step functions for the
// pattern BIST driver; the bench model reuses the same step functions.
package pattern_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RUN,
        FLUSH,
        DONE
    } state_e;

    localparam logic [15:0] DEF_LFSR_POLY = 16'hB400;
    localparam logic [15:0] DEF_MISR_POLY = 16'hB400;
    localparam logic [15:0] DEF_SEED      = 16'hACE1;
    localparam int          INIT_CYCLES   = 2;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s, input logic [15:0] poly);
        return (s >> 1) ^ (s[0] ? poly : 16'h0000);
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [15:0] poly,
                                              input logic [15:0] data);
        return (sig << 1) ^ (sig[15] ? poly : 16'h0000) ^ data;
    endfunction

    // An all-zero Galois LFSR never leaves zero, so the seed is forced nonzero.
    function automatic logic [15:0] seed_fix(input logic [15:0] s);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

endpackage

// File: rtl/pattern_bist_driver_misr.sv
// 16-bit MISR with synchronous clear and capture enable; also exposes the
// next-state value so the caller can latch the final signature on the same edge.
module pattern_bist_misr
    import pattern_bist_pkg::*;
#(
    parameter logic [15:0] POLY = DEF_MISR_POLY
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [15:0] data_i,
    output logic [15:0] sig_o,
    output logic [15:0] sig_d_o
);

    logic [15:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr_i)
            sig_d = 16'h0000;
        else if (en_i)
            sig_d = misr_step(sig_q, POLY, data_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            sig_q <= 16'h0000;
        else
            sig_q <= sig_d;
    end

    assign sig_o   = sig_q;
    assign sig_d_o = sig_d;

endmodule

// File: rtl/pattern_bist_driver.sv
// LFSR stimulus / MISR response driver for a generated pattern netlist.
// Optional macro PATTERN_BIST_DRIVER_SEED_PORT_EN adds a per-run seed_in port.
module pattern_bist_driver
    import pattern_bist_pkg::*;
#(
    parameter int          IN_W      = 15,
    parameter int          OUT_W     = 13,
    parameter int          PAT_CNT   = 256,
    parameter int          DUT_LAT   = 1,
    parameter logic [15:0] LFSR_POLY = DEF_LFSR_POLY,
    parameter logic [15:0] MISR_POLY = DEF_MISR_POLY,
    parameter logic [15:0] SEED      = DEF_SEED
) (
    input  logic             blif_clk_net,
    input  logic             blif_reset_net,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      golden_sig,
`ifdef PATTERN_BIST_DRIVER_SEED_PORT_EN
    input  logic [15:0]      seed_in,
`endif
    output logic             dut_rst,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      signature
);

    state_e            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [15:0]       golden_q, golden_d;
    logic [IN_W-1:0]   hold_q, hold_d;
    logic [15:0]       sig_q, sig_d;
    logic              pass_q, pass_d;
    logic [DUT_LAT-1:0] vld_q;
    logic [DUT_LAT:0]  vld_pipe;
    logic [15:0]       run_seed;
    logic [15:0]       misr_sig, misr_d;
    logic              misr_clr, issue, capture, abort_run;

`ifdef PATTERN_BIST_DRIVER_SEED_PORT_EN
    assign run_seed = seed_fix(seed_in);
`else
    assign run_seed = seed_fix(SEED);
`endif

    assign issue     = (state_q == RUN);
    assign vld_pipe  = {vld_q, issue};
    assign capture   = vld_pipe[DUT_LAT];
    assign abort_run = abort && (state_q inside {INIT, RUN, FLUSH});

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lfsr_d   = lfsr_q;
        golden_d = golden_q;
        hold_d   = hold_q;
        sig_d    = sig_q;
        pass_d   = pass_q;
        misr_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    golden_d = golden_sig;
                    lfsr_d   = run_seed;
                    misr_clr = 1'b1;
                    cnt_d    = 16'd0;
                    hold_d   = '0;
                    pass_d   = 1'b0;
                    state_d  = INIT;
                end
            end
            INIT: begin
                if (cnt_q == 16'(INIT_CYCLES - 1)) begin
                    cnt_d   = 16'd0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RUN: begin
                hold_d = lfsr_q[IN_W-1:0];
                lfsr_d = lfsr_step(lfsr_q, LFSR_POLY);
                if (cnt_q == 16'(PAT_CNT - 1)) begin
                    cnt_d   = 16'd0;
                    state_d = FLUSH;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            FLUSH: begin
                // Final capture lands on this edge, so latch the MISR's next value.
                if (cnt_q == 16'(DUT_LAT - 1)) begin
                    cnt_d   = 16'd0;
                    sig_d   = misr_d;
                    pass_d  = (misr_d == golden_q);
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_run) begin
            state_d = IDLE;
            cnt_d   = 16'd0;
            pass_d  = 1'b0;
        end
    end

    always_ff @(posedge blif_clk_net) begin
        if (blif_reset_net) begin
            state_q  <= IDLE;
            cnt_q    <= 16'd0;
            lfsr_q   <= seed_fix(SEED);
            golden_q <= 16'h0000;
            hold_q   <= '0;
            sig_q    <= 16'h0000;
            pass_q   <= 1'b0;
            vld_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
            golden_q <= golden_d;
            hold_q   <= hold_d;
            sig_q    <= sig_d;
            pass_q   <= pass_d;
            vld_q    <= abort_run ? '0 : vld_pipe[DUT_LAT-1:0];
        end
    end

    pattern_bist_misr #(.POLY(MISR_POLY)) u_misr (
        .clk_i   (blif_clk_net),
        .rst_i   (blif_reset_net),
        .clr_i   (misr_clr),
        .en_i    (capture),
        .data_i  (16'(dut_out)),
        .sig_o   (misr_sig),
        .sig_d_o (misr_d)
    );

    // RUN shows the live LFSR; elsewhere the last applied pattern (0 during INIT).
    assign dut_in    = (state_q == RUN) ? lfsr_q[IN_W-1:0] : hold_q;
    assign dut_rst   = (state_q == INIT);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign pass      = pass_q;
    assign signature = sig_q;

endmodule

// File: tb/tb_pattern_bist_driver.sv
// Directed bench: a default 256-pattern driver (A) and a 4-pattern driver (B)
// whose DUT is either a constant or a registered loopback of its stimulus.
module tb_pattern_bist_driver;

    logic        clk = 1'b0;
    logic        rst, abort, start_a, start_b, loop_en, sel;
    logic [15:0] golden;
    logic [12:0] dout_c, loop_q, dout_b;

    logic        dut_rst_a, busy_a, done_a, pass_a;
    logic [14:0] dut_in_a;
    logic [15:0] sig_a;
    logic        dut_rst_b, busy_b, done_b, pass_b;
    logic [14:0] dut_in_b;
    logic [15:0] sig_b;
    logic        busy_s, done_s;

    int errs = 0;
    int checks = 0;
    int nb, nd;

    always #5 clk = ~clk;

    pattern_bist_driver u_dut_a (
        .blif_clk_net   (clk),
        .blif_reset_net (rst),
        .start          (start_a),
        .abort          (abort),
        .golden_sig     (golden),
`ifdef PATTERN_BIST_DRIVER_SEED_PORT_EN
        .seed_in        (16'hACE1),
`endif
        .dut_rst        (dut_rst_a),
        .dut_in         (dut_in_a),
        .dut_out        (dout_c),
        .busy           (busy_a),
        .done           (done_a),
        .pass           (pass_a),
        .signature      (sig_a)
    );

    pattern_bist_driver #(.PAT_CNT(4)) u_dut_b (
        .blif_clk_net   (clk),
        .blif_reset_net (rst),
        .start          (start_b),
        .abort          (abort),
        .golden_sig     (golden),
`ifdef PATTERN_BIST_DRIVER_SEED_PORT_EN
        .seed_in        (16'hACE1),
`endif
        .dut_rst        (dut_rst_b),
        .dut_in         (dut_in_b),
        .dut_out        (dout_b),
        .busy           (busy_b),
        .done           (done_b),
        .pass           (pass_b),
        .signature      (sig_b)
    );

    // One-cycle-latency stand-in DUT: out = in[12:0] ^ 13'h1555.
    always @(posedge clk) loop_q <= dut_in_b[12:0] ^ 13'h1555;
    assign dout_b = loop_en ? loop_q : dout_c;
    assign busy_s = sel ? busy_b : busy_a;
    assign done_s = sel ? done_b : done_a;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic pulse_start(input bit b);
        @(negedge clk);
        if (b) start_b = 1'b1;
        else   start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_run(input int bound, output int n_busy, output int n_done);
        n_busy = 0;
        n_done = 0;
        for (int i = 0; i < bound; i++) begin
            if (!busy_s) break;
            n_busy++;
            if (done_s) n_done++;
            @(negedge clk);
        end
        if (busy_s) chk("run_timeout", busy_s, 0);
    endtask

    initial begin
        rst = 1'b1; abort = 1'b0; start_a = 1'b0; start_b = 1'b0;
        loop_en = 1'b0; sel = 1'b0; golden = 16'h0000; dout_c = 13'h0000;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0);
        chk("rst_sig", sig_a, 0);
        chk("rst_din", dut_in_a, 0);
        chk("rst_drst", dut_rst_a, 0);
        rst = 1'b0;

        // Run A, constant-zero response: reset window and first patterns.
        pulse_start(0);
        chk("init1_drst", dut_rst_a, 1);
        chk("init1_din", dut_in_a, 0);
        chk("init1_busy", busy_a, 1);
        @(negedge clk);
        chk("init2_drst", dut_rst_a, 1);
        @(negedge clk);
        chk("run0_drst", dut_rst_a, 0);
        chk("pat0", dut_in_a, 15'h2CE1);
        @(negedge clk);
        chk("pat1", dut_in_a, 15'h6270);
        wait_run(400, nb, nd);
        chk("a_busy_rest", nb, 257);
        chk("a_done_cnt", nd, 1);
        chk("a_sig", sig_a, 16'h0000);
        chk("a_pass", pass_a, 1);

        // Run B, response tied to 1; golden changes after start to prove latching.
        sel = 1'b1; dout_c = 13'h0001; golden = 16'h000F;
        pulse_start(1);
        golden = 16'h1234;
        wait_run(50, nb, nd);
        chk("b1_busy", nb, 8);
        chk("b1_done", nd, 1);
        chk("b1_sig", sig_b, 16'h000F);
        chk("b1_pass", pass_b, 1);

        golden = 16'h000E;
        pulse_start(1);
        wait_run(50, nb, nd);
        chk("b2_sig", sig_b, 16'h000F);
        chk("b2_pass", pass_b, 0);

        // Loopback DUT: hand-folded signature of 4 LFSR patterns.
        loop_en = 1'b1; golden = 16'h9427;
        pulse_start(1);
        wait_run(50, nb, nd);
        chk("b3_sig", sig_b, 16'h9427);
        chk("b3_pass", pass_b, 1);
        loop_en = 1'b0;

        // Abort A in RUN cycle 10.
        sel = 1'b0; dout_c = 13'h0000; golden = 16'h0000;
        pulse_start(0);
        repeat (12) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_busy", busy_a, 0);
        chk("ab_drst", dut_rst_a, 0);
        chk("ab_done", done_a, 0);
        chk("ab_pass", pass_a, 0);
        @(negedge clk);
        chk("ab_idle", busy_a, 0);
        pulse_start(0);
        wait_run(400, nb, nd);
        chk("re_busy", nb, 260);
        chk("re_done", nd, 1);
        chk("re_sig", sig_a, 16'h0000);
        chk("re_pass", pass_a, 1);

        // start and abort together in IDLE: abort wins.
        @(negedge clk);
        start_a = 1'b1; abort = 1'b1;
        @(negedge clk);
        start_a = 1'b0; abort = 1'b0;
        chk("sa_busy", busy_a, 0);

        // B: start while busy is ignored; reset in FLUSH clears everything.
        sel = 1'b1; dout_c = 13'h0001; golden = 16'h000F;
        pulse_start(1);
        @(negedge clk);
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        chk("busy_start_drst", dut_rst_b, 0);
        repeat (3) @(negedge clk);
        chk("flush_busy", busy_b, 1);
        chk("flush_din", dut_in_b, 15'h389C);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_busy", busy_b, 0);
        chk("mr_done", done_b, 0);
        chk("mr_pass", pass_b, 0);
        chk("mr_sig", sig_b, 0);
        chk("mr_din", dut_in_b, 0);
        chk("mr_drst", dut_rst_b, 0);
        nb = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy_b || done_b) nb++;
        end
        chk("mr_no_restart", nb, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
